toggle_pulse_pacer: RTL

//  Sits directly upstream of the toggle pulse synchronizer, in the generating-clock domain.

---
 rtl/pacer_pkg.sv | 18 +
 rtl/sat_updown_cnt.sv | 30 +++
 rtl/toggle_pulse_pacer.sv | 83 ++++++++
 3 files changed

// File: rtl/pacer_pkg.sv
// Shared definitions for the toggle pulse pacer: FSM encoding and MIN_GAP limits.
package pacer_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        GAP  = 1'b1
    } pacer_state_e;

    localparam int unsigned PACER_MIN_GAP_DEF = 4;
    localparam int unsigned PACER_MIN_GAP_LO  = 2;
    localparam int unsigned PACER_MIN_GAP_HI  = 255;
    localparam int unsigned PACER_GAP_W       = 8;

    function automatic bit pacer_min_gap_ok(input int unsigned gap);
        return (gap >= PACER_MIN_GAP_LO) && (gap <= PACER_MIN_GAP_HI);
    endfunction

endpackage

// File: rtl/sat_updown_cnt.sv
// Saturating up/down counter with synchronous clear; ovf flags an increment lost at full scale.
module sat_updown_cnt #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             dec,
    input  logic             clr,
    output logic [WIDTH-1:0] cnt,
    output logic             ovf
);

    always_comb begin
        ovf = inc && !dec && !clr && (cnt == '1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && !dec && (cnt != '1)) begin
            cnt <= cnt + WIDTH'(1);
        end else if (dec && !inc && (cnt != '0)) begin
            cnt <= cnt - WIDTH'(1);
        end
    end

endmodule

// File: rtl/toggle_pulse_pacer.sv
// Buffers incoming event pulses and re-emits them one at a time, at least MIN_GAP cycles apart,
// ahead of a toggle synchronizer so no event is merged or lost.
module toggle_pulse_pacer
    import pacer_pkg::*;
#(
    parameter int unsigned CNT_WIDTH = 4,
    parameter int unsigned MIN_GAP   = PACER_MIN_GAP_DEF
) (
    input  logic                 macCoreClk,
    input  logic                 hardReset,
    input  logic                 pulseIn,
    input  logic                 flush,
    input  logic                 clearOverflow,
    output logic                 pulseOut,
    output logic [CNT_WIDTH-1:0] pendingCnt,
    output logic                 overflow,
    output logic                 busy
);

    if (!pacer_min_gap_ok(MIN_GAP)) begin : g_bad_min_gap
        $error("toggle_pulse_pacer: MIN_GAP=%0d outside legal range 2..255", MIN_GAP);
    end

    localparam logic [PACER_GAP_W-1:0] GAP_LOAD = PACER_GAP_W'(MIN_GAP - 1);

    pacer_state_e           state;
    logic [PACER_GAP_W-1:0] gapCnt;
    logic                   work;
    logic                   fire;
    logic                   cntOvf;

    // gapCnt reads MIN_GAP-1 in the pulse cycle and 0 in the last gap cycle,
    // so a decision taken at 0 lands exactly MIN_GAP cycles after the previous pulse.
    always_comb begin
        work = ((pendingCnt != '0) || pulseIn) && !flush;
        fire = work && ((state == IDLE) || (gapCnt == '0));
    end

    sat_updown_cnt #(
        .WIDTH (CNT_WIDTH)
    ) u_pending (
        .clk (macCoreClk),
        .rst (hardReset),
        .inc (pulseIn),
        .dec (fire),
        .clr (flush),
        .cnt (pendingCnt),
        .ovf (cntOvf)
    );

    always_ff @(posedge macCoreClk or posedge hardReset) begin
        if (hardReset) begin
            state    <= IDLE;
            gapCnt   <= '0;
            pulseOut <= 1'b0;
            overflow <= 1'b0;
        end else begin
            pulseOut <= fire;

            if (cntOvf) begin
                overflow <= 1'b1;
            end else if (clearOverflow) begin
                overflow <= 1'b0;
            end

            if (fire) begin
                state  <= GAP;
                gapCnt <= GAP_LOAD;
            end else if (state == GAP) begin
                if (gapCnt == '0) begin
                    state <= IDLE;
                end else begin
                    gapCnt <= gapCnt - PACER_GAP_W'(1);
                end
            end
        end
    end

    always_comb begin
        busy = (state == GAP) || (pendingCnt != '0);
    end

endmodule
